// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor, D = A - B, one bit per clock, LSB first,
//            through a single full-subtractor cell with a registered borrow.
//            Operands are captured on a start/busy/done handshake. Results
//            are held until the next operation completes.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled only while idle
//            a, b   - minuend / subtrahend, captured on the accept edge
//            busy   - high while an operation is in progress
//            done   - single-cycle completion pulse
//            d      - difference (a - b) mod 2^WIDTH
//            bout   - final borrow (1 when a < b unsigned)
//            ovf    - signed overflow, present only with SERSUB_OVF_EN
// Config   : `define SERSUB_OVF_EN to add the ovf port and MSB capture.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_d_sh;     // upper bits of the result collected so far
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
`ifdef SERSUB_OVF_EN
    logic               r_a_msb;
    logic               r_b_msb;
`endif

    // Full-subtractor cell on the current LSBs
    logic             w_x;
    logic             w_y;
    logic             w_r;
    logic             w_diff;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_d_next;

    assign w_x           = r_a_sh[0];
    assign w_y           = r_b_sh[0];
    assign w_r           = r_borrow;
    assign w_diff        = w_x ^ w_y ^ w_r;
    assign w_borrow_next = (~w_x & w_y) | (~w_x & w_r) | (w_y & w_r);
    // New bit enters at the MSB; after WIDTH shifts this is the full result.
    assign w_d_next      = {w_diff, r_d_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_d_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            bout     <= 1'b0;
`ifdef SERSUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_d_sh   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
`ifdef SERSUB_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_d_sh   <= w_d_next[WIDTH-1:1];
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        // Last bit: publish the result, the only place the
                        // visible outputs change outside reset.
                        d       <= w_d_next;
                        bout    <= w_borrow_next;
`ifdef SERSUB_OVF_EN
                        ovf     <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH=4): vector
//            table plus directed sequences for start/operand changes during
//            RUN, back-to-back operation and mid-RUN reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } vec_t;

    vec_t vecs[9];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ovf(input string name, input logic exp);
`ifdef SERSUB_OVF_EN
        chk(name, 32'(ovf), 32'(exp));
`else
        if (exp === 1'bx) $display("unexpected X in ovf expectation for %s", name);
`endif
    endtask

    // One full operation with a start pulse; checks busy, latency, result.
    task automatic run_op(input vec_t v, input string name);
        int cyc;
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        @(posedge clk); #1;
        chk({name, " busy@accept"}, 32'(busy), 32'd1);
        start = 1'b0;
        a     = ~v.a;   // operands may change freely after accept
        b     = ~v.b;
        cyc   = 0;
        while (!done && cyc < 20) begin
            if (busy !== 1'b1) begin
                chk({name, " busy during RUN"}, 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'(WIDTH));
        chk({name, " d"}, 32'(d), 32'(v.d));
        chk({name, " bout"}, 32'(bout), 32'(v.bout));
        chk({name, " busy@done"}, 32'(busy), 32'd0);
        chk_ovf({name, " ovf"}, v.ovf);
        @(posedge clk); #1;
        chk({name, " done pulse width"}, 32'(done), 32'd0);
        chk({name, " d held"}, 32'(d), 32'(v.d));
    endtask

    vec_t bb[3];
    int   n_done;
    vec_t v_mid;

    initial begin
        n_vec = 0;
        n_err = 0;
        //            a        b        d        bout  ovf
        vecs[0] = '{4'b0110, 4'b0101, 4'b0001, 1'b0, 1'b0};
        vecs[1] = '{4'b0101, 4'b0110, 4'b1111, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1};
        vecs[5] = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0};
        vecs[6] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
        vecs[7] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0};
        vecs[8] = '{4'b1100, 4'b0011, 4'b1001, 1'b0, 1'b0};

        bb[0] = '{4'b0110, 4'b0101, 4'b0001, 1'b0, 1'b0};
        bb[1] = '{4'b1100, 4'b0011, 4'b1001, 1'b0, 1'b0};
        bb[2] = '{4'b0010, 4'b0111, 4'b1011, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset d", 32'(d), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        chk_ovf("reset ovf", 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start toggled and operands changed while running 1001 - 0011
        v_mid  = '{4'b1001, 4'b0011, 4'b0110, 1'b0, 1'b1};
        start  = 1'b1;
        a      = v_mid.a;
        b      = v_mid.b;
        n_done = 0;
        @(posedge clk); #1;     // accept
        for (int i = 1; i <= 12; i++) begin
            start = (i <= 3) ? i[0] : 1'b0;
            a     = 4'(i * 3);
            b     = 4'(i * 5);
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                chk("ign cycle", 32'(i), 32'(WIDTH));
                chk("ign d", 32'(d), 32'(v_mid.d));
                chk("ign bout", 32'(bout), 32'(v_mid.bout));
                chk_ovf("ign ovf", v_mid.ovf);
            end
        end
        chk("ign done count", 32'(n_done), 32'd1);

        // start held high for three back-to-back operations
        start  = 1'b1;
        a      = bb[0].a;
        b      = bb[0].b;
        n_done = 0;
        @(posedge clk); #1;     // E0
        a = bb[1].a;
        b = bb[1].b;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                a = bb[2].a;
                b = bb[2].b;
            end
            if (i == 10) start = 1'b0;
            if (done) begin
                if (n_done < 3) begin
                    chk($sformatf("b2b%0d cycle", n_done), 32'(i), 32'(4 + 5 * n_done));
                    chk($sformatf("b2b%0d d", n_done), 32'(d), 32'(bb[n_done].d));
                    chk($sformatf("b2b%0d bout", n_done), 32'(bout), 32'(bb[n_done].bout));
                    chk_ovf($sformatf("b2b%0d ovf", n_done), bb[n_done].ovf);
                end
                n_done++;
            end
        end
        chk("b2b done count", 32'(n_done), 32'd3);

        // reset mid-RUN after a prior result of 0110
        run_op(v_mid, "pre-reset");
        start = 1'b1;
        a     = 4'b0101;
        b     = 4'b0110;
        @(posedge clk); #1;     // accept
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst d", 32'(d), 32'd0);
        chk("rst bout", 32'(bout), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk_ovf("rst ovf", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("rst no done", 32'(n_done), 32'd0);
        chk("rst d stays 0", 32'(d), 32'd0);
        run_op(vecs[4], "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
